// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/execute sequencer and decoder for the 16-bit Datapath.
// Owns the program counter, instruction register and latched ALU flags; sequences ROM fetch and RAM load/store.
module control_unit #(
   parameter logic [5:0] RESET_PC = 6'd0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [5:0]  instr_addr,
   input  logic [15:0] instr_data,
   input  logic [15:0] a_bus,
   input  logic [15:0] b_bus,
   input  logic        V,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   output logic        MD,
   output logic        RW,
   output logic        ASEL,
   output logic [1:0]  MB,
   output logic [3:0]  FS,
   output logic [3:0]  SA,
   output logic [3:0]  DR,
   output logic [3:0]  BA,
   output logic [5:0]  PC,
   output logic [15:0] imdt,
   output logic [15:0] ram_addr,
   output logic        ram_we,
   output logic [15:0] ram_din,
   output logic        halted
);

   localparam int unsigned PC_W   = 6;
   localparam int unsigned IR_W   = 16;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_LD   = 4'h3;
   localparam logic [3:0] OP_ST   = 4'h4;
   localparam logic [3:0] OP_JAL  = 4'h5;
   localparam logic [3:0] OP_BRZ  = 4'h6;
   localparam logic [3:0] OP_BRN  = 4'h7;
   localparam logic [3:0] OP_JR   = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] MB_IMDT = 2'b01;
   localparam logic [1:0] MB_PC   = 2'b10;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
   logic [IR_W-1:0]     ir_q, ir_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;   // {V, C, N, Z}

   logic [3:0] op, fd, fs_, ft;
   logic       unused_flags;

   assign op  = ir_q[15:12];
   assign fd  = ir_q[11:8];
   assign fs_ = ir_q[7:4];
   assign ft  = ir_q[3:0];

   assign pc_inc     = pc_q + 6'd1;
   assign instr_addr = pc_q;
   assign PC         = pc_inc;
   assign ram_addr   = a_bus;
   assign ram_din    = b_bus;

   // V and C are latched for completeness but no instruction consumes them
   assign unused_flags = ^flags_q[3:2];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

   // Next-state: sequencing, pc update and flag latching
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      case (state_q)
         S_FETCH: begin
            ir_d    = instr_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            case (op)
               OP_ALU:  flags_d = {V, C, N, Z};
               OP_LD:   state_d = S_WB;
               OP_JAL:  pc_d = ir_q[5:0];
               OP_BRZ:  if (flags_q[FLAG_Z]) pc_d = ir_q[5:0];
               OP_BRN:  if (flags_q[FLAG_N]) pc_d = ir_q[5:0];
               OP_JR:   pc_d = a_bus[5:0];
               OP_HALT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               default: ;
            endcase
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Output decode: everything zero outside EXEC/WB except halted
   always_comb begin
      MD     = 1'b0;
      RW     = 1'b0;
      ASEL   = 1'b0;
      MB     = 2'b00;
      FS     = 4'h0;
      SA     = 4'h0;
      DR     = 4'h0;
      BA     = 4'h0;
      imdt   = 16'h0000;
      ram_we = 1'b0;
      halted = 1'b0;
      case (state_q)
         S_EXEC: begin
            imdt = {8'h00, ir_q[7:0]};
            case (op)
               OP_ALU: begin
                  ASEL = 1'b1;
                  DR   = fd;
                  BA   = fs_;
                  FS   = ft;
                  RW   = 1'b1;
               end
               OP_LDI: begin
                  DR = fd;
                  MB = MB_IMDT;
                  RW = 1'b1;
               end
               OP_LD: begin
                  SA = fs_;
                  DR = fd;
               end
               OP_ST: begin
                  SA     = fs_;
                  BA     = ft;
                  ram_we = 1'b1;
               end
               OP_JAL: begin
                  DR = fd;
                  MB = MB_PC;
                  RW = 1'b1;
               end
               OP_JR:   SA = fs_;
               default: ;
            endcase
         end
         S_WB: begin
            MD = 1'b1;
            RW = 1'b1;
            DR = fd;
            SA = fs_;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model plus directed scenarios,
// followed by randomized programs with random Datapath buses and flags.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  instr_addr;
   logic [15:0] instr_data;
   wire  [15:0] a_bus, b_bus;
   wire         V, C, N, Z;
   logic        MD, RW, ASEL, ram_we, halted;
   logic [1:0]  MB;
   logic [3:0]  FS, SA, DR, BA;
   logic [5:0]  PC;
   logic [15:0] imdt, ram_addr, ram_din;

   logic [15:0] rom [64];
   logic        rnd_en = 1'b0;
   logic        chk_en = 1'b0;
   logic [15:0] r_a = '0, r_b = '0, dir_a = '0, dir_b = '0;
   logic [3:0]  r_f = '0, dir_f = '0;   // {V, C, N, Z}
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   assign instr_data   = rom[instr_addr];
   assign a_bus        = rnd_en ? r_a : dir_a;
   assign b_bus        = rnd_en ? r_b : dir_b;
   assign {V, C, N, Z} = rnd_en ? r_f : dir_f;

   control_unit #(.RESET_PC(6'd0)) dut (
      .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
      .a_bus(a_bus), .b_bus(b_bus), .V(V), .C(C), .N(N), .Z(Z),
      .MD(MD), .RW(RW), .ASEL(ASEL), .MB(MB), .FS(FS), .SA(SA), .DR(DR), .BA(BA),
      .PC(PC), .imdt(imdt), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
      .halted(halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: where the program is and which cycle of the instruction it is in
   logic [5:0]  m_pc;
   logic [15:0] m_ir;
   logic [1:0]  m_ph;      // 0 fetch, 1 execute, 2 load writeback, 3 halted
   logic        m_n, m_z;
   logic [5:0]  m_link;
   assign m_link = m_pc + 6'd1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc <= 6'd0; m_ir <= 16'h0; m_ph <= 2'd0; m_n <= 1'b0; m_z <= 1'b0;
      end else begin
         case (m_ph)
            2'd0: begin m_ir <= rom[m_pc]; m_ph <= 2'd1; end
            2'd1: begin
               m_ph <= 2'd0;
               m_pc <= m_link;
               case (m_ir[15:12])
                  4'h1: begin m_n <= N; m_z <= Z; end
                  4'h3: m_ph <= 2'd2;
                  4'h5: m_pc <= m_ir[5:0];
                  4'h6: if (m_z) m_pc <= m_ir[5:0];
                  4'h7: if (m_n) m_pc <= m_ir[5:0];
                  4'h8: m_pc <= a_bus[5:0];
                  4'hF: begin m_pc <= m_pc; m_ph <= 2'd3; end
                  default: ;
               endcase
            end
            2'd2:    m_ph <= 2'd0;
            default: ;
         endcase
      end
   end

   // Expected {MD,RW,ASEL,MB,FS,SA,DR,BA,ram_we,halted}
   function automatic logic [22:0] exp_ctrl(input logic [1:0] ph, input logic [15:0] ir);
      logic md, rw, asel, we, hl;
      logic [1:0] mb;
      logic [3:0] fs, sa, dr, ba;
      {md, rw, asel, we, hl} = 5'b0;
      mb = 2'b0; fs = 4'h0; sa = 4'h0; dr = 4'h0; ba = 4'h0;
      if (ph == 2'd3) hl = 1'b1;
      else if (ph == 2'd2) begin md = 1'b1; rw = 1'b1; dr = ir[11:8]; sa = ir[7:4]; end
      else if (ph == 2'd1) begin
         case (ir[15:12])
            4'h1: begin asel = 1'b1; dr = ir[11:8]; ba = ir[7:4]; fs = ir[3:0]; rw = 1'b1; end
            4'h2: begin dr = ir[11:8]; mb = 2'b01; rw = 1'b1; end
            4'h3: begin sa = ir[7:4]; dr = ir[11:8]; end
            4'h4: begin sa = ir[7:4]; ba = ir[3:0]; we = 1'b1; end
            4'h5: begin dr = ir[11:8]; mb = 2'b10; rw = 1'b1; end
            4'h8: sa = ir[7:4];
            default: ;
         endcase
      end
      return {md, rw, asel, mb, fs, sa, dr, ba, we, hl};
   endfunction

   logic [22:0] act_ctrl;
   assign act_ctrl = {MD, RW, ASEL, MB, FS, SA, DR, BA, ram_we, halted};

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr_addr", 32'(instr_addr), 32'(m_pc));
         chk("ctrl", 32'(act_ctrl), 32'(exp_ctrl(m_ph, m_ir)));
         chk("PC_link", 32'(PC), 32'(m_link));
         chk("imdt", 32'(imdt), (m_ph == 2'd1) ? 32'(m_ir[7:0]) : 32'd0);
         chk("ram_addr", 32'(ram_addr), 32'(a_bus));
         chk("ram_din", 32'(ram_din), 32'(b_bus));
         chk("rw_we_excl", 32'(RW & ram_we), 32'd0);
      end
   end

   // Random Datapath inputs change just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         r_a = 16'($urandom);
         r_b = 16'($urandom);
         r_f = 4'($urandom);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_addr", 32'(instr_addr), 32'd0);
      chk("rst_rw_halt", 32'({RW, ram_we, halted}), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) begin
         logic [3:0] op;
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) op = 4'hF;
         else if (r < 10) op = 4'($urandom_range(9, 14));
         else op = 4'($urandom_range(0, 8));
         rom[i] = {op, 12'($urandom)};
      end
   endtask

   initial begin
      reset = 1'b0;
      clear_rom();
      do_reset();
      chk_en = 1'b1;

      // LDI R10,0x5C
      clear_rom(); rom[0] = 16'h2A5C;
      do_reset();
      step(1);
      chk("ldi_rw", 32'(RW), 32'd1);
      chk("ldi_mb", 32'(MB), 32'd1);
      chk("ldi_dr", 32'(DR), 32'd10);
      chk("ldi_imdt", 32'(imdt), 32'h005C);
      step(1);
      chk("ldi_pc", 32'(instr_addr), 32'd1);

      // ALU producing Z=1, then BRZ taken; live Z flipped to prove latching
      clear_rom(); rom[0] = 16'h1120; rom[1] = 16'h6020;
      dir_f = 4'b0001;
      do_reset();
      step(2);
      dir_f = 4'b0000;
      step(2);
      chk("brz_taken", 32'(instr_addr), 32'h20);
      do_reset();
      step(2);
      dir_f = 4'b0001;
      step(2);
      chk("brz_not_taken", 32'(instr_addr), 32'd2);
      dir_f = 4'b0000;

      // LD R3,(R1)
      clear_rom(); rom[0] = 16'h3310; dir_a = 16'h0040;
      do_reset();
      step(1);
      chk("ld_exec_addr", 32'(ram_addr), 32'h0040);
      chk("ld_exec_rw_we", 32'({RW, ram_we}), 32'd0);
      step(1);
      chk("ld_wb_md_rw", 32'({MD, RW, ram_we}), 32'b110);
      chk("ld_wb_dr", 32'(DR), 32'd3);
      step(1);
      chk("ld_3cyc", 32'(instr_addr), 32'd1);

      // ST (R1),R2
      clear_rom(); rom[0] = 16'h4012; dir_b = 16'hBEEF;
      do_reset();
      step(1);
      chk("st_we", 32'({ram_we, RW}), 32'b10);
      chk("st_din", 32'(ram_din), 32'hBEEF);
      step(1);
      chk("st_we_drop", 32'(ram_we), 32'd0);

      // JAL to 10, JAL R15 to 63, NOP at 63 wraps
      clear_rom(); rom[0] = 16'h500A; rom[10] = 16'h5F3F;
      do_reset();
      step(2);
      chk("jal_tgt", 32'(instr_addr), 32'd10);
      step(1);
      chk("jal_link", 32'(PC), 32'd11);
      chk("jal_mb_rw_dr", 32'({MB, RW, DR}), 32'({2'b10, 1'b1, 4'd15}));
      step(1);
      chk("jal_63", 32'(instr_addr), 32'd63);
      step(2);
      chk("pc_wrap", 32'(instr_addr), 32'd0);

      // HALT holds for 20 cycles
      clear_rom(); rom[0] = 16'hF000;
      do_reset();
      step(2);
      for (int i = 0; i < 20; i++) begin
         chk("halt_state", 32'({halted, instr_addr}), 32'({1'b1, 6'd0}));
         step(1);
      end

      // Reset during LD writeback aborts the write
      clear_rom(); rom[0] = 16'h3310; rom[1] = 16'h0000;
      do_reset();
      step(2);
      chk("wb_before_rst", 32'(RW), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("wb_rst_rw", 32'({MD, RW}), 32'd0);
      chk("wb_rst_pc", 32'(instr_addr), 32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      step(1);
      chk("after_rst_exec", 32'({RW, instr_addr}), 32'd0);

      // Randomized programs with random buses and flags
      rnd_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
         fill_random();
         do_reset();
         step(300);
         @(negedge clk);
         #2 reset = 1'b1;
         @(negedge clk);
         #2 reset = 1'b0;
         step(200);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle instruction sequencer and decoder that drives every control input of the 16-bit Datapath: MD, RW, ASEL, MB, FS, SA, DR, BA, PC and imdt.
- Owns the 6-bit program counter, the instruction register and the latched flags.
- Fetches from a 64-word instruction ROM and sequences data-RAM loads and stores.
- Consumes the Datapath's V/C/N/Z and A_out/B_out buses.

Parameters:
RESET_PC, 6'd0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
instr_addr  out  6  instruction ROM address (= pc register)
instr_data  in  16  instruction ROM data, combinational, valid same cycle
a_bus  in  16  Datapath A_out
b_bus  in  16  Datapath B_out
V, C, N, Z  in  1 each  Datapath ALU flags, combinational
MD, RW, ASEL  out  1 each  Datapath controls
MB  out  2  Datapath MB select: 00 ALU/RAM, 01 imdt, 10 PC
FS, SA, DR, BA  out  4 each  Datapath controls
PC  out  6  link value to Datapath = pc+1 (mod 64), always driven
imdt  out  16  {8'b0, IR[7:0]}
ram_addr  out  16  data RAM address = a_bus
ram_we  out  1  data RAM write strobe
ram_din  out  16  data RAM write data = b_bus
halted  out  1  high in HALT state

Behaviour:
- States: FETCH, EXEC, WB, HALT.
- Reset (async) values: state=FETCH, pc=RESET_PC, IR=0, flags VCNZ=0.
- In FETCH every control output is 0, including RW and ram_we; halted=0.
- FETCH: IR <= instr_data; next state EXEC.
- EXEC: outputs are decoded from IR. At the clock edge:
  - pc <= pc+1, 6-bit wrap: 63 -> 0.
  - A taken branch or jump instead loads the target.
  - Next state is FETCH, except LD -> WB and HALT -> HALT.
- WB (LD only): MD=1, MB=00, RW=1, DR=IR[11:8], SA=IR[7:4]; ram_addr still = a_bus. Next state FETCH.
- HALT: all strobes 0, halted=1; pc and IR frozen. Exit only by reset.
- Instruction fields: op=IR[15:12], d=IR[11:8], s=IR[7:4], t=IR[3:0].
- Decode in EXEC. Any signal not listed for an opcode is 0.
  - 0x0 NOP: no strobes.
  - 0x1 ALU: ASEL=1, DR=d, BA=s, FS=t, MB=00, MD=0, RW=1. Result R[d] <= R[d] op R[s]. Flags VCNZ <= V,C,N,Z at the edge.
  - 0x2 LDI: DR=d, MB=01, RW=1. Result R[d] <= zext(IR[7:0]).
  - 0x3 LD: SA=s, DR=d. RAM is read at the EXEC edge; data is written in WB. Total 3 cycles.
  - 0x4 ST: SA=s, BA=t, ram_we=1. Result M[R[s]] <= R[t].
  - 0x5 JAL: DR=d, MB=10, RW=1. Result R[d] <= pc+1; pc <= IR[5:0].
  - 0x6 BRZ: if latched Z=1, pc <= IR[5:0].
  - 0x7 BRN: if latched N=1, pc <= IR[5:0].
  - 0x8 JR: SA=s; pc <= a_bus[5:0].
  - 0xF HALT: pc is not incremented.
  - All other opcodes: NOP.
- Flags change only on ALU ops. A branch tests flags latched by an earlier instruction, never the live V/C/N/Z.
- Cycle counts: LD 3 cycles; all other instructions 2 cycles.
- RW and ram_we are strictly single-cycle and never both high in the same cycle.
- Reset asserted mid-LD (in WB) aborts the instruction: no register write, pc=RESET_PC on release.
- JAL with d equal to the register read by a following JR is legal; the link value is visible on the next instruction.

Test Plan:
1. Reset, ROM[0]=0x2A5C (LDI R10,0x5C) -> EXEC: RW=1, MB=01, DR=10, imdt=0x005C; pc=1 after 2 cycles.
2. ALU with FS=t, result zero (Z=1 from Datapath), followed by BRZ 0x6020 -> pc jumps to 0x20 in EXEC of BRZ. Same sequence with Z=0 -> pc increments by 1.
3. LD 0x3310 with a_bus=0x0040 -> ram_addr=0x0040, RW=0 in EXEC; WB: MD=1, RW=1, DR=3; 3 cycles total; ram_we stays 0.
4. ST 0x4012 with b_bus=0xBEEF -> ram_we=1 for exactly one cycle, ram_din=0xBEEF, RW=0.
5. JAL 0x5F3F at pc=10 -> PC port=11, MB=10, RW=1, DR=15; next instr_addr=63. Then NOP at 63 -> instr_addr wraps to 0.
6. HALT 0xF000 -> halted=1, instr_addr constant for 20 cycles. Assert reset during a LD WB cycle -> RW drops immediately, pc=0.
